// File: rtl/dlx_decode_stage_if.sv
// Purpose: bundles the fetch->decode handshake and the decoded-control bus of the DLX decode stage.
// Latency: none, wiring only; the stage behind the slave modport registers the bundle once.
// Backpressure: in_ready/out_ready close the valid-ready loop; DLX_DECODE_ILLEGAL_TRAP_EN adds the illegal flag.
interface dlx_decode_stage_if #(
    parameter int XLEN = 32
);
    // Upstream handshake (fetch side)
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;

    // Downstream handshake (ALU / PC / data-memory side)
    logic            out_valid;
    logic            out_ready;

    // Decoded bundle
    logic [3:0]      alu_op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            imm_sel;
    logic            pc_alu;
    logic [1:0]      pc_cmd;
    logic [1:0]      pc_val;
    logic            d_load;
    logic            d_store;
`ifdef DLX_DECODE_ILLEGAL_TRAP_EN
    logic            illegal;
`endif

    // Environment view: drives instructions and consumes bundles
    modport master (
        output flush, in_valid, in_instr, out_ready,
        input  in_ready, out_valid,
        input  alu_op, rs1, rs2, rd, imm, imm_sel, pc_alu, pc_cmd, pc_val, d_load, d_store
`ifdef DLX_DECODE_ILLEGAL_TRAP_EN
        , input illegal
`endif
    );

    // Decode-stage view
    modport slave (
        input  flush, in_valid, in_instr, out_ready,
        output in_ready, out_valid,
        output alu_op, rs1, rs2, rd, imm, imm_sel, pc_alu, pc_cmd, pc_val, d_load, d_store
`ifdef DLX_DECODE_ILLEGAL_TRAP_EN
        , output illegal
`endif
    );
endinterface

// File: rtl/dlx_decode_stage.sv
// Purpose: DLX instruction decode stage with load-use interlock and branch flush; optional DLX_DECODE_ILLEGAL_TRAP_EN.
// Latency: 1 cycle from accepted instruction to registered bundle with out_valid.
// Backpressure: bundle holds while out_valid && !out_ready; in_ready drops on hold or load-use hazard.
module dlx_decode_stage #(
    parameter int XLEN           = 32,
    parameter int LOAD_USE_STALL = 1,
    parameter int LINK_REG       = 31
) (
    input  logic               clk,
    input  logic               reset_n,
    dlx_decode_stage_if.slave  bus
);

    localparam int         CNT_W = (LOAD_USE_STALL > 0) ? $clog2(LOAD_USE_STALL + 1) : 1;
    localparam logic [4:0] LINK  = 5'(LINK_REG);

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQZ  = 6'h04;
    localparam logic [5:0] OP_BNEZ  = 6'h05;
    localparam logic [5:0] OP_JR    = 6'h12;
    localparam logic [5:0] OP_JALR  = 6'h13;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // Registered part of the decoded result
    typedef struct packed {
        logic [3:0]      alu_op;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            imm_sel;
        logic            pc_alu;
        logic [1:0]      pc_cmd;
        logic [1:0]      pc_val;
        logic            d_load;
        logic            d_store;
`ifdef DLX_DECODE_ILLEGAL_TRAP_EN
        logic            illegal;
`endif
    } bundle_t;

    // Instruction fields
    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic [4:0]      f_rs1;
    logic [4:0]      f_rs2;
    logic [4:0]      f_rd;
    logic [XLEN-1:0] imm_sext;
    logic [XLEN-1:0] imm_zext;
    logic [XLEN-1:0] imm_jump;

    assign opcode   = bus.in_instr[31:26];
    assign funct    = bus.in_instr[5:0];
    assign f_rs1    = bus.in_instr[25:21];
    assign f_rs2    = bus.in_instr[20:16];
    assign f_rd     = bus.in_instr[15:11];
    assign imm_sext = {{(XLEN-16){bus.in_instr[15]}}, bus.in_instr[15:0]};
    assign imm_zext = {{(XLEN-16){1'b0}}, bus.in_instr[15:0]};
    assign imm_jump = {{(XLEN-26){bus.in_instr[25]}}, bus.in_instr[25:0]};

    // Combinational decode results
    bundle_t    dec;
    logic       dec_use_rs1;
    logic       dec_use_rs2;

    // I-type table lookup results
    logic       i_ok;
    logic [3:0] i_op;
    logic       i_sext;
    logic       r_ok;
    logic [3:0] r_op;

    // Pipeline state
    bundle_t           bundle_q;
    logic              out_valid_q;
    logic [CNT_W-1:0]  stall_cnt;
    logic [4:0]        load_rd;
    logic              hazard;
    logic              accept;
    logic              in_ready_c;

    // R-type funct lookup; an unlisted funct makes the whole word a NOP
    always_comb begin
        r_ok = 1'b1;
        r_op = 4'd0;
        case (funct)
            6'h20:   r_op = 4'd1;
            6'h22:   r_op = 4'd2;
            6'h24:   r_op = 4'd3;
            6'h25:   r_op = 4'd4;
            6'h26:   r_op = 4'd5;
            6'h04:   r_op = 4'd6;
            6'h06:   r_op = 4'd7;
            6'h28:   r_op = 4'd10;
            6'h2c:   r_op = 4'd11;
            6'h2a:   r_op = 4'd12;
            6'h29:   r_op = 4'd13;
            6'h07:   r_op = 4'd14;
            default: r_ok = 1'b0;
        endcase
    end

    // I-type opcode lookup: ALU op and immediate extension kind
    always_comb begin
        i_ok   = 1'b1;
        i_op   = 4'd0;
        i_sext = 1'b1;
        case (opcode)
            6'h08:   i_op = 4'd1;
            6'h0a:   i_op = 4'd2;
            6'h18:   i_op = 4'd10;
            6'h1c:   i_op = 4'd11;
            6'h1a:   i_op = 4'd12;
            6'h19:   i_op = 4'd13;
            6'h0c:   begin i_op = 4'd3;  i_sext = 1'b0; end
            6'h0d:   begin i_op = 4'd4;  i_sext = 1'b0; end
            6'h0e:   begin i_op = 4'd5;  i_sext = 1'b0; end
            6'h14:   begin i_op = 4'd6;  i_sext = 1'b0; end
            6'h16:   begin i_op = 4'd7;  i_sext = 1'b0; end
            6'h17:   begin i_op = 4'd14; i_sext = 1'b0; end
            6'h0f:   begin i_op = 4'd0;  i_sext = 1'b0; end
            OP_LW:   i_op = 4'd1;
            OP_SW:   i_op = 4'd1;
            OP_BEQZ: i_op = 4'd8;
            OP_BNEZ: i_op = 4'd9;
            OP_JR:   begin i_op = 4'd0;  i_sext = 1'b0; end
            OP_JALR: begin i_op = 4'd15; i_sext = 1'b0; end
            default: i_ok = 1'b0;
        endcase
    end

    // Assemble the decoded bundle and the register-read set used by the interlock
    always_comb begin
        dec         = '0;
        dec_use_rs1 = 1'b0;
        dec_use_rs2 = 1'b0;
        if (opcode == OP_RTYPE) begin
            if (r_ok) begin
                dec.alu_op  = r_op;
                dec.rs1     = f_rs1;
                dec.rs2     = f_rs2;
                dec.rd      = f_rd;
                dec_use_rs1 = 1'b1;
                dec_use_rs2 = 1'b1;
            end
`ifdef DLX_DECODE_ILLEGAL_TRAP_EN
            else begin
                dec.illegal = 1'b1;
            end
`endif
        end else if (opcode == OP_J || opcode == OP_JAL) begin
            dec.alu_op = (opcode == OP_JAL) ? 4'd15 : 4'd0;
            dec.rd     = (opcode == OP_JAL) ? LINK : 5'd0;
            dec.imm    = imm_jump;
            dec.pc_cmd = 2'd2;
            dec.pc_alu = 1'b1;
            dec.pc_val = 2'd1;
        end else if (i_ok) begin
            dec.alu_op  = i_op;
            dec.rs1     = f_rs1;
            dec.rs2     = f_rs2;
            dec.rd      = f_rs2;
            dec.imm     = i_sext ? imm_sext : imm_zext;
            dec.imm_sel = 1'b1;
            dec_use_rs1 = 1'b1;
            case (opcode)
                OP_LW: dec.d_load = 1'b1;
                OP_SW: begin
                    dec.d_store = 1'b1;
                    dec.rd      = 5'd0;
                    dec_use_rs2 = 1'b1;
                end
                OP_BEQZ, OP_BNEZ: begin
                    dec.pc_cmd = 2'd2;
                    dec.rd     = 5'd0;
                end
                OP_JR: begin
                    dec.pc_cmd = 2'd3;
                    dec.pc_val = 2'd3;
                    dec.rd     = 5'd0;
                end
                OP_JALR: begin
                    dec.pc_cmd = 2'd3;
                    dec.pc_val = 2'd3;
                    dec.rd     = LINK;
                end
                default: ;
            endcase
        end
`ifdef DLX_DECODE_ILLEGAL_TRAP_EN
        else begin
            dec.illegal = 1'b1;
        end
`endif
    end

    // Load-use hazard: a pending load's destination is read by the presented instruction
    always_comb begin
        hazard = 1'b0;
        if (bus.in_valid && (stall_cnt != '0) && (load_rd != 5'd0)) begin
            hazard = (dec_use_rs1 && (dec.rs1 == load_rd)) ||
                     (dec_use_rs2 && (dec.rs2 == load_rd));
        end
    end

    // flush absorbs (and drops) whatever is presented, so ready reads high then
    assign in_ready_c = bus.flush || ((!out_valid_q || bus.out_ready) && !hazard);
    assign accept     = bus.in_valid && in_ready_c && !bus.flush;

    // Output register: flush beats accept and hold; a bubble clears valid when the consumer drains
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            bundle_q    <= dec;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Interlock counter: armed by an accepted load, counts down, cleared by flush
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            load_rd   <= 5'd0;
        end else if (bus.flush) begin
            stall_cnt <= '0;
        end else if (accept && dec.d_load && (dec.rd != 5'd0)) begin
            stall_cnt <= CNT_W'(LOAD_USE_STALL);
            load_rd   <= dec.rd;
        end else if (stall_cnt != '0) begin
            stall_cnt <= stall_cnt - 1'b1;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.alu_op    = bundle_q.alu_op;
    assign bus.rs1       = bundle_q.rs1;
    assign bus.rs2       = bundle_q.rs2;
    assign bus.rd        = bundle_q.rd;
    assign bus.imm       = bundle_q.imm;
    assign bus.imm_sel   = bundle_q.imm_sel;
    assign bus.pc_alu    = bundle_q.pc_alu;
    assign bus.pc_cmd    = bundle_q.pc_cmd;
    assign bus.pc_val    = bundle_q.pc_val;
    assign bus.d_load    = bundle_q.d_load;
    assign bus.d_store   = bundle_q.d_store;
`ifdef DLX_DECODE_ILLEGAL_TRAP_EN
    assign bus.illegal   = bundle_q.illegal;
`endif

endmodule
